// File: rtl/gpgpu_rf_pkg.sv
// Shared widths and response record for the register-file bank, its
// request FIFO and the operand collectors.
package gpgpu_rf_pkg;

    localparam int ROWS       = 8;
    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 256;
    localparam int OCID_W     = 4;
    localparam int RESP_DEPTH = 2;
    localparam int STALL_W    = 16;

    // One queued read response: who asked, which row, and the row contents.
    typedef struct packed {
        logic [OCID_W-1:0] ocid;
        logic [ADDR_W-1:0] row;
        logic [DATA_W-1:0] data;
    } rf_resp_t;

    localparam int RESP_W = $bits(rf_resp_t);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rf_resp_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished by the pointer difference alone.
// The head word is presented combinationally and forced to zero when empty.
module rf_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [WIDTH-1:0] entries_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push_en;
    logic             pop_en;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (count == '0);
    // Illegal requests (push when full, pop when empty) are ignored.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = empty ? '0 : entries_q[rd_ptr_q[PW-2:0]];

    // Next pointers and storage update for this cycle's push/pop.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(push_en);
        rd_ptr_d  = rd_ptr_q + PW'(pop_en);
        entries_d = entries_q;
        if (push_en) begin
            entries_d[wr_ptr_q[PW-2:0]] = din;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule

// File: rtl/rf_bank_responder.sv
// One register-file bank answering queued operand reads. CDB write-back
// owns the single bank port whenever it is active; reads are accepted only
// in write-free cycles with space in the response FIFO.
module rf_bank_responder
    import gpgpu_rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [OCID_W-1:0]   req_ocid,
    output logic                req_ready,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_row,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                resp_valid,
    output logic [OCID_W-1:0]   resp_ocid,
    output logic [ADDR_W-1:0]   resp_row,
    output logic [DATA_W-1:0]   resp_data,
    input  logic                resp_ready,
    output logic [STALL_W-1:0]  stall_cnt
);

    localparam int PW = $clog2(RESP_DEPTH) + 1;

    logic [DATA_W-1:0]  mem_q [ROWS];
    logic [DATA_W-1:0]  mem_d [ROWS];
    logic [ROWS-1:0]    row_wr_sel;
    logic [DATA_W-1:0]  rd_data;

    logic [PW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    rf_resp_t           push_entry;
    rf_resp_t           head_entry;

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Row write decode; a row address beyond ROWS selects nothing, so the
    // write is dropped.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_sel
            assign row_wr_sel[gi] = wr_en && (wr_row == ADDR_W'(gi));
        end
    endgenerate

    // Next bank contents: the selected row takes the write-back data.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            mem_d[i] = row_wr_sel[i] ? wr_data : mem_q[i];
        end
    end

    // Read mux over pre-edge contents; unmatched addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

    // Bank register array; reset clears every row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Write-back wins the port. Ready never looks at resp_ready, so a full
    // FIFO that pops this cycle still refuses and reopens one cycle later.
    assign req_ready  = !rst && !wr_en && (fifo_count < PW'(RESP_DEPTH));
    assign fifo_push  = req_valid && req_ready && !fifo_full;
    assign fifo_pop   = resp_ready && !fifo_empty;
    assign push_entry = {req_ocid, req_addr, rd_data};

    rf_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign resp_ocid  = head_entry.ocid;
    assign resp_row   = head_entry.row;
    assign resp_data  = head_entry.data;

    // Count cycles where a read is blocked by write-back, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (req_valid && wr_en) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_bank_responder.sv
// Bench for rf_bank_responder: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_rf_bank_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [2:0]   req_addr;
    logic [3:0]   req_ocid;
    logic         req_ready;
    logic         wr_en;
    logic [2:0]   wr_row;
    logic [255:0] wr_data;
    logic         resp_valid;
    logic [3:0]   resp_ocid;
    logic [2:0]   resp_row;
    logic [255:0] resp_data;
    logic         resp_ready;
    logic [15:0]  stall_cnt;

    typedef struct packed {
        logic [3:0]   ocid;
        logic [2:0]   row;
        logic [255:0] data;
    } exp_t;

    logic [255:0] mem_m [8];
    exp_t         q_m[$];
    int           stall_m;
    int           checks   = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    rf_bank_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ocid   (req_ocid),
        .req_ready  (req_ready),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .resp_valid (resp_valid),
        .resp_ocid  (resp_ocid),
        .resp_row   (resp_row),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .stall_cnt  (stall_cnt)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
        stall_m = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".resp_valid"}, 256'(resp_valid), 256'(q_m.size() > 0));
        if (q_m.size() > 0) begin
            check({tag, ".resp_ocid"}, 256'(resp_ocid), 256'(q_m[0].ocid));
            check({tag, ".resp_row"},  256'(resp_row),  256'(q_m[0].row));
            check({tag, ".resp_data"}, resp_data, q_m[0].data);
        end else begin
            check({tag, ".idle_tags"}, 256'({resp_ocid, resp_row}), 256'(0));
            check({tag, ".idle_data"}, resp_data, 256'(0));
        end
        check({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(stall_m));
    endtask

    // One clock cycle: drive, check ready, clock, update model, check outputs.
    task automatic step(input string tag, input logic r, input logic rv,
                        input logic [2:0] ra, input logic [3:0] ro,
                        input logic we, input logic [2:0] wrow,
                        input logic [255:0] wd, input logic rr);
        logic exp_ready;
        logic accept;
        rst = r; req_valid = rv; req_addr = ra; req_ocid = ro;
        wr_en = we; wr_row = wrow; wr_data = wd; resp_ready = rr;
        #1;
        exp_ready = !r && !we && (q_m.size() < 2);
        check({tag, ".req_ready"}, 256'(req_ready), 256'(exp_ready));
        accept = rv && exp_ready;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (rr && q_m.size() > 0) void'(q_m.pop_front());
            if (accept) q_m.push_back({ro, ra, mem_m[ra]});
            if (we) mem_m[wrow] = wd;
            if (rv && we && stall_m < 16'hFFFF) stall_m++;
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        logic [255:0] a5;
        logic [255:0] d4;
        logic [255:0] d5;
        a5 = {32{8'hA5}};
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_ocid = '0;
        wr_en = 1'b0; wr_row = '0; wr_data = '0; resp_ready = 1'b0;
        model_reset();

        // Reset, then a read of row 3 returns zeros tagged ocid 5.
        step("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, 1, 3, 5, 0, 0, 0, 0);
        step("rd3",    0, 1, 3, 5, 0, 0, 0, 0);
        step("rd3pop", 0, 0, 0, 0, 0, 0, 0, 1);

        // Write row 2, the concurrent read is refused, the next one sees it.
        step("wr2",    0, 1, 2, 1, 1, 2, a5, 1);
        step("rd2",    0, 1, 2, 1, 0, 0, 0, 1);
        step("rd2pop", 0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: only two reads fit; the third waits one bubble.
        step("bp0", 0, 1, 0, 2, 0, 0, 0, 0);
        step("bp1", 0, 1, 1, 3, 0, 0, 0, 0);
        step("bp2", 0, 1, 2, 4, 0, 0, 0, 0);
        step("bp3", 0, 1, 2, 4, 0, 0, 0, 1);
        step("bp4", 0, 1, 2, 4, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("bpdrain", 0, 0, 0, 0, 0, 0, 0, 1);

        // Streaming: eight back-to-back reads with distinct ocids.
        for (int i = 0; i < 8; i++) begin
            step("stream", 0, 1, 3'(i), 4'(i + 8), 0, 0, 0, 1);
        end
        step("streamdrain", 0, 0, 0, 0, 0, 0, 0, 1);

        // Stall counter: five blocked cycles.
        for (int i = 0; i < 5; i++) step("stall", 0, 1, 6, 1, 1, 7, rand_data(), 1);

        // Saturation: hold the blocked condition long enough to reach FFFF.
        rst = 0; req_valid = 1; wr_en = 1; wr_row = 0; wr_data = '0; resp_ready = 1;
        repeat (65600) @(posedge clk);
        #1;
        mem_m[0] = '0;
        stall_m  = 16'hFFFF;
        q_m.delete();
        check("stall_sat", 256'(stall_cnt), 256'(16'hFFFF));
        step("sat_hold", 0, 1, 0, 0, 1, 0, 0, 1);

        // Reset mid-flight: queue two responses over written rows, then reset.
        d4 = rand_data();
        d5 = rand_data();
        step("mf_wr4", 0, 0, 0, 0, 1, 4, d4, 1);
        step("mf_wr5", 0, 0, 0, 0, 1, 5, d5, 1);
        step("mf_rd4", 0, 1, 4, 9, 0, 0, 0, 0);
        step("mf_rd5", 0, 1, 5, 10, 0, 0, 0, 0);
        step("mf_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        step("mf_re4", 0, 1, 4, 9, 0, 0, 0, 1);
        step("mf_re5", 0, 1, 5, 10, 0, 0, 0, 1);
        step("mf_dr",  0, 0, 0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            step("rand", 0, 1'($urandom_range(0, 1)), 3'($urandom()), 4'($urandom()),
                 ($urandom_range(0, 3) == 0), 3'($urandom()), rand_data(),
                 ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
